// File: rtl/fetch_stage64.sv
// fetch_stage64: fetch PC generation, credit-limited instruction memory requests
// and an allocate-at-request queue that pairs in-order responses with their PCs.
module fetch_stage64 #(
   parameter int               XLEN              = 64,
   parameter logic [XLEN-1:0]  RESET_PC          = '0,
   parameter int               QUEUE_DEPTH       = 4,
   parameter int               QUEUE_INDEX_WIDTH = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                redirect_valid_i,
   input  logic [XLEN-1:0]     redirect_PC_i,
   input  logic                NLP_hit_i,
   input  logic [XLEN-1:0]     NLP_target_i,
   output logic                i_mem_request_valid_o,
   input  logic                i_mem_request_ready_i,
   output logic [XLEN-1:0]     i_mem_request_address_o,
   input  logic                i_mem_response_valid_i,
   input  logic [31:0]         i_mem_response_instruction_i,
   output logic                fetch_response_valid_o,
   input  logic                fetch_response_ready_i,
   output logic [31:0]         fetch_response_instruction_o,
   output logic [XLEN-1:0]     fetch_response_PC_o,
   output logic                fetch_NLP_BTB_hit_o
);
   localparam int CW = QUEUE_INDEX_WIDTH + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

   logic [XLEN-1:0]              pc_q, pc_d;
   logic [QUEUE_INDEX_WIDTH-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
   logic [CW-1:0]                count_q, count_d, pend_q, pend_d, drop_q, drop_d;
   logic [XLEN-1:0]              ent_pc_q  [QUEUE_DEPTH];
   logic [31:0]                  ent_ins_q [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0]       ent_hit_q, ent_filled_q;
   logic                         alloc, resp_drop, resp_fill, pop;

   // pend_q tracks allocated-but-unfilled entries so a redirect knows how many responses to discard
   assign i_mem_request_valid_o   = !redirect_valid_i && (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_W);
   assign i_mem_request_address_o = pc_q;
   assign fetch_response_valid_o  = ent_filled_q[head_q] && !redirect_valid_i;
   assign fetch_response_instruction_o = ent_ins_q[head_q];
   assign fetch_response_PC_o     = ent_pc_q[head_q];
   assign fetch_NLP_BTB_hit_o     = ent_hit_q[head_q];

   assign alloc     = i_mem_request_valid_o && i_mem_request_ready_i;
   assign resp_drop = i_mem_response_valid_i && (drop_q != '0);
   assign resp_fill = i_mem_response_valid_i && (drop_q == '0) && (pend_q != '0);
   assign pop       = fetch_response_valid_o && fetch_response_ready_i;

   always_comb begin
      pc_d    = redirect_valid_i ? redirect_PC_i :
                alloc ? (NLP_hit_i ? NLP_target_i : pc_q + XLEN'(4)) : pc_q;
      head_d  = redirect_valid_i ? '0 : head_q + QUEUE_INDEX_WIDTH'(pop);
      fill_d  = redirect_valid_i ? '0 : fill_q + QUEUE_INDEX_WIDTH'(resp_fill);
      tail_d  = redirect_valid_i ? '0 : tail_q + QUEUE_INDEX_WIDTH'(alloc);
      count_d = redirect_valid_i ? '0 : count_q + CW'(alloc) - CW'(pop);
      pend_d  = redirect_valid_i ? '0 : pend_q + CW'(alloc) - CW'(resp_fill);
      drop_d  = redirect_valid_i ?
                drop_q + pend_q - CW'(i_mem_response_valid_i && (drop_q != '0 || pend_q != '0)) :
                drop_q - CW'(resp_drop);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         fill_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
         drop_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         fill_q  <= fill_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ent_pc_q     <= '{default: '0};
         ent_ins_q    <= '{default: '0};
         ent_hit_q    <= '0;
         ent_filled_q <= '0;
      end else if (redirect_valid_i) begin
         ent_filled_q <= '0;
      end else begin
         if (alloc) begin
            ent_pc_q[tail_q]     <= pc_q;
            ent_hit_q[tail_q]    <= NLP_hit_i;
            ent_filled_q[tail_q] <= 1'b0;
         end
         if (resp_fill) begin
            ent_ins_q[fill_q]    <= i_mem_response_instruction_i;
            ent_filled_q[fill_q] <= 1'b1;
         end
         if (pop) ent_filled_q[head_q] <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_stage64.sv
// tb_fetch_stage64: random stimulus against a queue-based reference model of the fetch stage.
module tb_fetch_stage64;
   localparam int DEPTH = 4;

   logic        clock = 1'b0, reset = 1'b1;
   logic        redirect_valid_i = 1'b0, NLP_hit_i = 1'b0;
   logic [63:0] redirect_PC_i = '0, NLP_target_i = '0;
   logic        i_mem_request_valid_o, i_mem_request_ready_i = 1'b0;
   logic [63:0] i_mem_request_address_o;
   logic        i_mem_response_valid_i = 1'b0;
   logic [31:0] i_mem_response_instruction_i = '0;
   logic        fetch_response_valid_o, fetch_response_ready_i = 1'b0;
   logic [31:0] fetch_response_instruction_o;
   logic [63:0] fetch_response_PC_o;
   logic        fetch_NLP_BTB_hit_o;

   fetch_stage64 dut (
      .clock(clock), .reset(reset),
      .redirect_valid_i(redirect_valid_i), .redirect_PC_i(redirect_PC_i),
      .NLP_hit_i(NLP_hit_i), .NLP_target_i(NLP_target_i),
      .i_mem_request_valid_o(i_mem_request_valid_o), .i_mem_request_ready_i(i_mem_request_ready_i),
      .i_mem_request_address_o(i_mem_request_address_o),
      .i_mem_response_valid_i(i_mem_response_valid_i),
      .i_mem_response_instruction_i(i_mem_response_instruction_i),
      .fetch_response_valid_o(fetch_response_valid_o), .fetch_response_ready_i(fetch_response_ready_i),
      .fetch_response_instruction_o(fetch_response_instruction_o),
      .fetch_response_PC_o(fetch_response_PC_o), .fetch_NLP_BTB_hit_o(fetch_NLP_BTB_hit_o)
   );

   always #5 clock = ~clock;

   typedef struct { logic [63:0] pc; bit hit; logic [31:0] ins; bit f; } ent_t;
   typedef struct { logic [63:0] a; int due; } mreq_t;

   ent_t        mq[$];
   mreq_t       memq[$];
   int          drop = 0, cyc = 0, last_due = -1;
   logic [63:0] mpc = '0;
   int          checks = 0, errors = 0;
   int          p_ready, p_dready, p_hit, p_redir, lat_max;
   bit          directed_hit;

   function automatic logic [31:0] ifn(input logic [63:0] a);
      return a[31:0] ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit redir, hit, rv_in, erv, efv, acc, pop;
      logic [63:0] tgt;
      int unf, due;
      @(negedge clock);
      redir = $urandom_range(99) < p_redir;
      if (directed_hit) begin
         hit = (mpc == 64'h8);
         tgt = 64'h100;
      end else begin
         hit = $urandom_range(99) < p_hit;
         tgt = {$urandom, $urandom} & ~64'h3;
      end
      rv_in = memq.size() > 0 && memq[0].due <= cyc;
      redirect_valid_i             = redir;
      redirect_PC_i                = {$urandom, $urandom} & ~64'h3;
      NLP_hit_i                    = hit;
      NLP_target_i                 = tgt;
      i_mem_request_ready_i        = $urandom_range(99) < p_ready;
      fetch_response_ready_i       = $urandom_range(99) < p_dready;
      i_mem_response_valid_i       = rv_in;
      i_mem_response_instruction_i = rv_in ? ifn(memq[0].a) : $urandom;
      if (rv_in) void'(memq.pop_front());
      #1;
      erv = !redir && (mq.size() + drop < DEPTH);
      efv = !redir && mq.size() > 0 && mq[0].f;
      check("req_valid", i_mem_request_valid_o, erv);
      check("req_addr", i_mem_request_address_o, mpc);
      check("fetch_valid", fetch_response_valid_o, efv);
      if (efv) begin
         check("fetch_pc", fetch_response_PC_o, mq[0].pc);
         check("fetch_ins", fetch_response_instruction_o, mq[0].ins);
         check("fetch_hit", fetch_NLP_BTB_hit_o, mq[0].hit);
      end
      acc = erv && i_mem_request_ready_i;
      pop = efv && fetch_response_ready_i;
      if (redir) begin
         unf = 0;
         foreach (mq[i]) if (!mq[i].f) unf++;
         drop = drop + unf - ((rv_in && drop + unf > 0) ? 1 : 0);
         mq.delete();
         mpc = redirect_PC_i;
      end else begin
         if (rv_in) begin
            if (drop > 0) drop--;
            else
               for (int i = 0; i < mq.size(); i++)
                  if (!mq[i].f) begin
                     mq[i].ins = i_mem_response_instruction_i;
                     mq[i].f = 1;
                     break;
                  end
         end
         if (pop) void'(mq.pop_front());
         if (acc) begin
            due = cyc + $urandom_range(lat_max, 1);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{a: mpc, due: due});
            mq.push_back('{pc: mpc, hit: hit, ins: 32'h0, f: 1'b0});
            mpc = hit ? tgt : mpc + 64'd4;
         end
      end
      cyc++;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_req_valid"}, i_mem_request_valid_o, 1);
      check({tag, "_req_addr"}, i_mem_request_address_o, 0);
      check({tag, "_fetch_valid"}, fetch_response_valid_o, 0);
      check({tag, "_fetch_ins"}, fetch_response_instruction_o, 0);
      check({tag, "_fetch_pc"}, fetch_response_PC_o, 0);
      check({tag, "_fetch_hit"}, fetch_NLP_BTB_hit_o, 0);
   endtask

   task automatic mid_reset();
      redirect_valid_i = 1'b0;
      #2 reset = 1'b1;
      #1 reset_checks("async_rst");
      mq.delete();
      memq.delete();
      drop = 0;
      mpc = '0;
      last_due = -1;
      @(posedge clock);
      #2 reset = 1'b0;
   endtask

   task automatic knobs(input int r, input int d, input int h, input int x, input int l, input bit dh);
      p_ready = r; p_dready = d; p_hit = h; p_redir = x; lat_max = l; directed_hit = dh;
   endtask

   initial begin
      #12 reset_checks("reset");
      reset = 1'b0;
      knobs(100, 100, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 4) check("seq_addr", i_mem_request_address_o, 64'(i * 4));
         if (i == 2) begin
            check("first_valid", fetch_response_valid_o, 1);
            check("first_pc", fetch_response_PC_o, 0);
            check("first_ins", fetch_response_instruction_o, 32'h13);
         end
      end
      mid_reset();
      knobs(100, 100, 0, 0, 1, 1);
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 3) check("nlp_addr", i_mem_request_address_o, 64'h100);
      end
      mid_reset();
      knobs(100, 0, 0, 0, 2, 0);
      for (int i = 0; i < 10; i++) step();
      check("full_stall", i_mem_request_valid_o, 0);
      knobs(100, 100, 0, 0, 2, 0);
      for (int i = 0; i < 10; i++) step();
      knobs(100, 100, 20, 15, 3, 0);
      for (int i = 0; i < 800; i++) step();
      knobs(60, 50, 30, 8, 4, 0);
      for (int i = 0; i < 800; i++) step();
      mid_reset();
      knobs(80, 20, 10, 25, 5, 0);
      for (int i = 0; i < 800; i++) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
